// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD image controller.
// The LCD_ROTATE_EN macro, when defined, enables the rotate commands.
package lcd_pkg;

  localparam int IMG_DIM = 8;
  localparam int ADDR_W  = 6;
  localparam int PIX_N   = 64;

  typedef enum logic [3:0] {
    CMD_WRITE    = 4'h0,
    CMD_UP       = 4'h1,
    CMD_DOWN     = 4'h2,
    CMD_LEFT     = 4'h3,
    CMD_RIGHT    = 4'h4,
    CMD_MAX      = 4'h5,
    CMD_MIN      = 4'h6,
    CMD_AVG      = 4'h7,
    CMD_ROT_CCW  = 4'h8,
    CMD_ROT_CW   = 4'h9,
    CMD_MIRROR_X = 4'hA,
    CMD_MIRROR_Y = 4'hB
  } cmd_e;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    IDLE  = 2'd1,
    EXEC  = 2'd2,
    WRITE = 2'd3
  } state_e;

  // Linear buffer address of pixel (x, y) in the 8x8 image.
  function automatic logic [ADDR_W-1:0] pix_addr(input logic [2:0] x, input logic [2:0] y);
    return {y, x};
  endfunction

endpackage

// File: rtl/lcd_win_alu.sv
// Combinational pixel transform for the 2x2 operation window.
// Rotate commands (8/9) exist only when LCD_ROTATE_EN is defined; otherwise
// they fall through to the no-write default.
module lcd_win_alu
  import lcd_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [3:0]        cmd,
  input  logic [DATA_W-1:0] p0,
  input  logic [DATA_W-1:0] p1,
  input  logic [DATA_W-1:0] p2,
  input  logic [DATA_W-1:0] p3,
  output logic [DATA_W-1:0] n0,
  output logic [DATA_W-1:0] n1,
  output logic [DATA_W-1:0] n2,
  output logic [DATA_W-1:0] n3,
  output logic              we
);

  function automatic logic [DATA_W-1:0] pix_max(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [DATA_W-1:0] pix_min(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  logic [DATA_W+1:0] sum_s;
  logic [DATA_W-1:0] res_s;

  // Compute the new window pixels and whether they are written back.
  always_comb begin
    n0    = p0;
    n1    = p1;
    n2    = p2;
    n3    = p3;
    we    = 1'b0;
    res_s = p0;
    sum_s = {2'b00, p0} + {2'b00, p1} + {2'b00, p2} + {2'b00, p3};
    case (cmd)
      CMD_MAX: begin
        res_s = pix_max(pix_max(p0, p1), pix_max(p2, p3));
        n0 = res_s; n1 = res_s; n2 = res_s; n3 = res_s;
        we = 1'b1;
      end
      CMD_MIN: begin
        res_s = pix_min(pix_min(p0, p1), pix_min(p2, p3));
        n0 = res_s; n1 = res_s; n2 = res_s; n3 = res_s;
        we = 1'b1;
      end
      CMD_AVG: begin
        res_s = sum_s[DATA_W+1:2];
        n0 = res_s; n1 = res_s; n2 = res_s; n3 = res_s;
        we = 1'b1;
      end
`ifdef LCD_ROTATE_EN
      CMD_ROT_CCW: begin
        n0 = p1; n1 = p3; n3 = p2; n2 = p0;
        we = 1'b1;
      end
      CMD_ROT_CW: begin
        n0 = p2; n1 = p0; n3 = p1; n2 = p3;
        we = 1'b1;
      end
`endif
      CMD_MIRROR_X: begin
        n0 = p2; n2 = p0; n1 = p3; n3 = p1;
        we = 1'b1;
      end
      CMD_MIRROR_Y: begin
        n0 = p1; n1 = p0; n2 = p3; n3 = p2;
        we = 1'b1;
      end
      default: begin
        we = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/lcd_img_ctrl.sv
// LCD image controller: loads an 8x8 image from IROM, runs window commands,
// and streams the image to IRAM on a write command.
// Optional macro LCD_ROTATE_EN enables rotate commands in lcd_win_alu.
module lcd_img_ctrl
  import lcd_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ORIGIN_X = 4,
  parameter int ORIGIN_Y = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        cmd,
  input  logic              cmd_valid,
  input  logic [DATA_W-1:0] IROM_Q,
  output logic              IROM_rd,
  output logic [ADDR_W-1:0] IROM_A,
  output logic              IRAM_valid,
  output logic [DATA_W-1:0] IRAM_D,
  output logic [ADDR_W-1:0] IRAM_A,
  output logic              busy,
  output logic              done
);

  localparam logic [2:0] COORD_MAX = 3'(IMG_DIM - 1);

  state_e            state_r;
  logic [3:0]        cmd_r;
  logic [2:0]        win_x_r, win_y_r;
  logic [DATA_W-1:0] img_r [PIX_N];
  logic [ADDR_W-1:0] ld_addr_r;
  logic              ld_last_r;
  logic              cap_v_r;
  logic [ADDR_W-1:0] cap_a_r;
  logic [ADDR_W:0]   wr_cnt_r;

  logic [2:0]        xm1_s, ym1_s;
  logic [ADDR_W-1:0] a0_s, a1_s, a2_s, a3_s;
  logic [DATA_W-1:0] n0_s, n1_s, n2_s, n3_s;
  logic              we_s;

  // Buffer addresses of the four window pixels.
  always_comb begin
    xm1_s = win_x_r - 3'd1;
    ym1_s = win_y_r - 3'd1;
    a0_s  = pix_addr(xm1_s, ym1_s);
    a1_s  = pix_addr(win_x_r, ym1_s);
    a2_s  = pix_addr(xm1_s, win_y_r);
    a3_s  = pix_addr(win_x_r, win_y_r);
  end

  lcd_win_alu #(.DATA_W(DATA_W)) u_alu (
    .cmd (cmd_r),
    .p0  (img_r[a0_s]),
    .p1  (img_r[a1_s]),
    .p2  (img_r[a2_s]),
    .p3  (img_r[a3_s]),
    .n0  (n0_s),
    .n1  (n1_s),
    .n2  (n2_s),
    .n3  (n3_s),
    .we  (we_s)
  );

  // Image buffer: filled from IROM during load, window write-back in EXEC.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < PIX_N; i++) img_r[i] <= '0;
    end else if (state_r == LOAD && cap_v_r) begin
      img_r[cap_a_r] <= IROM_Q;
    end else if (state_r == EXEC && we_s) begin
      img_r[a0_s] <= n0_s;
      img_r[a1_s] <= n1_s;
      img_r[a2_s] <= n2_s;
      img_r[a3_s] <= n3_s;
    end
  end

  // Control FSM with registered memory-side and handshake outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= LOAD;
      cmd_r      <= 4'h0;
      win_x_r    <= 3'(ORIGIN_X);
      win_y_r    <= 3'(ORIGIN_Y);
      ld_addr_r  <= '0;
      ld_last_r  <= 1'b0;
      cap_v_r    <= 1'b0;
      cap_a_r    <= '0;
      wr_cnt_r   <= '0;
      IROM_rd    <= 1'b0;
      IROM_A     <= '0;
      IRAM_valid <= 1'b0;
      IRAM_D     <= '0;
      IRAM_A     <= '0;
      busy       <= 1'b1;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        LOAD: begin
          // Data for the address issued last cycle arrives this cycle.
          cap_v_r <= IROM_rd;
          cap_a_r <= IROM_A;
          if (!ld_last_r) begin
            IROM_rd   <= 1'b1;
            IROM_A    <= ld_addr_r;
            ld_addr_r <= ld_addr_r + 6'd1;
            ld_last_r <= (ld_addr_r == 6'd63);
          end else begin
            IROM_rd <= 1'b0;
          end
          if (cap_v_r && cap_a_r == 6'd63) begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end
        end
        IDLE: begin
          if (cmd_valid) begin
            cmd_r <= cmd;
            busy  <= 1'b1;
            if (cmd == CMD_WRITE) begin
              state_r  <= WRITE;
              wr_cnt_r <= '0;
            end else begin
              state_r <= EXEC;
            end
          end else begin
            busy <= 1'b0;
          end
        end
        EXEC: begin
          case (cmd_r)
            CMD_UP:    if (win_y_r > 3'd1)      win_y_r <= win_y_r - 3'd1;
            CMD_DOWN:  if (win_y_r < COORD_MAX) win_y_r <= win_y_r + 3'd1;
            CMD_LEFT:  if (win_x_r > 3'd1)      win_x_r <= win_x_r - 3'd1;
            CMD_RIGHT: if (win_x_r < COORD_MAX) win_x_r <= win_x_r + 3'd1;
            default:   win_x_r <= win_x_r;
          endcase
          state_r <= IDLE;
          busy    <= 1'b0;
        end
        WRITE: begin
          if (wr_cnt_r < 7'd64) begin
            IRAM_valid <= 1'b1;
            IRAM_A     <= wr_cnt_r[ADDR_W-1:0];
            IRAM_D     <= img_r[wr_cnt_r[ADDR_W-1:0]];
            wr_cnt_r   <= wr_cnt_r + 7'd1;
          end else if (wr_cnt_r == 7'd64) begin
            IRAM_valid <= 1'b0;
            done       <= 1'b1;
            wr_cnt_r   <= wr_cnt_r + 7'd1;
          end else begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end
        end
        default: begin
          state_r <= LOAD;
          busy    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_img_ctrl.sv
// Scoreboard bench for lcd_img_ctrl: IRAM writes and done pulses are checked
// by a monitor against an expectation queue filled when a write is issued.
module tb_lcd_img_ctrl;
  import lcd_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] cmd = 4'h0;
  logic       cmd_valid = 1'b0;
  logic [7:0] IROM_Q = 8'h00;
  logic       IROM_rd;
  logic [5:0] IROM_A;
  logic       IRAM_valid;
  logic [7:0] IRAM_D;
  logic [5:0] IRAM_A;
  logic       busy;
  logic       done;

  lcd_img_ctrl dut (
    .clk(clk), .reset(reset), .cmd(cmd), .cmd_valid(cmd_valid), .IROM_Q(IROM_Q),
    .IROM_rd(IROM_rd), .IROM_A(IROM_A), .IRAM_valid(IRAM_valid), .IRAM_D(IRAM_D),
    .IRAM_A(IRAM_A), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       is_done;
    logic [5:0] a;
    logic [7:0] d;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [7:0] model [64];
  int         n_vec = 0;
  int         n_err = 0;

  // Synchronous ROM holding IROM[i] = i.
  always @(posedge clk) if (IROM_rd) IROM_Q <= {2'b00, IROM_A};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: every IRAM write or done pulse consumes one expectation.
  always @(negedge clk) begin
    if (reset && (IRAM_valid || done)) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_output: valid=%0b done=%0b addr=%0d, expected nothing", IRAM_valid, done, IRAM_A);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.is_done) begin
          check("done_pulse", {31'd0, done & ~IRAM_valid}, 32'd1);
        end else begin
          check("iram_valid", {31'd0, IRAM_valid}, 32'd1);
          check("iram_addr", {26'd0, IRAM_A}, {26'd0, mon_e.a});
          check("iram_data", {24'd0, IRAM_D}, {24'd0, mon_e.d});
        end
      end
    end
  end

  task automatic set4(input int a0, input int a1, input int a2, input int a3,
                      input logic [7:0] v0, input logic [7:0] v1, input logic [7:0] v2, input logic [7:0] v3);
    model[a0] = v0; model[a1] = v1; model[a2] = v2; model[a3] = v3;
  endtask

  task automatic reset_load();
    int idx = 0, cnt = 0, bad = 0;
    bit started = 0;
    reset = 1'b0; cmd_valid = 1'b0; cmd = 4'h0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {8'd0, busy, IROM_rd, IROM_A, IRAM_valid, IRAM_D, IRAM_A, done}, 32'h0080_0000);
    for (int i = 0; i < 64; i++) model[i] = 8'(i);
    reset = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!busy) break;
      if (IROM_rd) begin
        started = 1;
        if (IROM_A != 6'(idx)) bad++;
        idx++;
      end
      if (started) cnt++;
    end
    check("load_addr_errors", bad, 0);
    check("load_reads", idx, 64);
    check("load_cycles", cnt, 65);
  endtask

  task automatic wait_idle();
    int k = 0;
    @(negedge clk);
    while (busy && k < 300) begin @(negedge clk); k++; end
    if (k >= 300) check("wait_idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic send_cmd(input logic [3:0] c);
    wait_idle();
    cmd = c; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd = 4'h0;
    @(negedge clk);
    check("exec_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("exec_release", {31'd0, busy}, 32'd0);
  endtask

  // Issue c, then keep cmd_valid high with hc until the controller is idle again.
  task automatic send_hold(input logic [3:0] c, input logic [3:0] hc);
    int k = 0;
    wait_idle();
    cmd = c; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd = hc;
    @(negedge clk);
    while (busy && k < 300) begin @(negedge clk); k++; end
    cmd_valid = 1'b0; cmd = 4'h0;
    check("hold_complete", {31'd0, k < 300}, 32'd1);
  endtask

  task automatic do_write(input bit hold_en, input logic [3:0] hc);
    int k = 0;
    wait_idle();
    for (int i = 0; i < 64; i++) exp_q.push_back('{1'b0, 6'(i), model[i]});
    exp_q.push_back('{1'b1, 6'd0, 8'd0});
    cmd = CMD_WRITE; cmd_valid = 1'b1;
    @(posedge clk); #1;
    if (hold_en) cmd = hc;
    else cmd_valid = 1'b0;
    @(negedge clk);
    while ((exp_q.size() != 0 || busy) && k < 300) begin @(negedge clk); k++; end
    cmd_valid = 1'b0; cmd = 4'h0;
    check("write_complete", {31'd0, k < 300}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Plain load then write: identity image.
    reset_load();
    do_write(0, 4'h0);
    // Max at origin window 27/28/35/36.
    send_cmd(4'h5);
    set4(27, 28, 35, 36, 8'd36, 8'd36, 8'd36, 8'd36);
    do_write(0, 4'h0);
    // Min after reload.
    reset_load();
    send_cmd(4'h6);
    set4(27, 28, 35, 36, 8'd27, 8'd27, 8'd27, 8'd27);
    do_write(0, 4'h0);
    // Average: 126 / 4 -> 31.
    reset_load();
    send_cmd(4'h7);
    set4(27, 28, 35, 36, 8'd31, 8'd31, 8'd31, 8'd31);
    do_write(0, 4'h0);
    // Mirror X, then mirror Y and a NOP.
    reset_load();
    send_cmd(4'hA);
    set4(27, 28, 35, 36, 8'd35, 8'd36, 8'd27, 8'd28);
    do_write(0, 4'h0);
    send_cmd(4'hB);
    send_cmd(4'hC);
    set4(27, 28, 35, 36, 8'd36, 8'd35, 8'd28, 8'd27);
    do_write(0, 4'h0);
    // Saturation at X=1 and Y=1.
    reset_load();
    repeat (5) send_cmd(4'h3);
    send_cmd(4'h5);
    set4(24, 25, 32, 33, 8'd33, 8'd33, 8'd33, 8'd33);
    repeat (6) send_cmd(4'h1);
    send_cmd(4'h6);
    set4(0, 1, 8, 9, 8'd0, 8'd0, 8'd0, 8'd0);
    do_write(0, 4'h0);
    // Saturation at X=7 and Y=7.
    reset_load();
    repeat (4) send_cmd(4'h4);
    repeat (4) send_cmd(4'h2);
    send_cmd(4'h6);
    set4(54, 55, 62, 63, 8'd54, 8'd54, 8'd54, 8'd54);
    do_write(0, 4'h0);
    // Rotations (no-ops without the rotate feature).
    reset_load();
    send_cmd(4'h9);
`ifdef LCD_ROTATE_EN
    set4(27, 28, 35, 36, 8'd35, 8'd27, 8'd36, 8'd28);
`endif
    do_write(0, 4'h0);
    send_cmd(4'h8);
    send_cmd(4'h8);
`ifdef LCD_ROTATE_EN
    set4(27, 28, 35, 36, 8'd28, 8'd36, 8'd27, 8'd35);
`endif
    do_write(0, 4'h0);
    // cmd_valid held through EXEC and WRITE busy cycles is ignored.
    reset_load();
    send_hold(4'h3, 4'h3);
    send_cmd(4'h5);
    set4(26, 27, 34, 35, 8'd35, 8'd35, 8'd35, 8'd35);
    do_write(1, 4'h6);
    do_write(0, 4'h0);
    // Reset in the middle of a write aborts it at once.
    reset_load();
    wait_idle();
    for (int i = 0; i < 30; i++) exp_q.push_back('{1'b0, 6'(i), model[i]});
    cmd = CMD_WRITE; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    begin
      int nv = 0, k = 0;
      while (nv < 30 && k < 200) begin
        @(negedge clk); k++;
        if (IRAM_valid) nv++;
      end
      check("midwrite_seen", nv, 30);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("reset_abort", {30'd0, IRAM_valid, done}, 32'd0);
    check("reset_queue_empty", exp_q.size(), 0);
    reset_load();
    do_write(0, 4'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
